// File: rtl/plot_sequencer.sv
// Round-robin pixel sequencer: presents each enabled player's pixel, then the timer-bar pixel,
// to the VGA plotter over a valid/ready handshake. It also owns the game countdown and running flag.
module plot_sequencer #(
  parameter int unsigned NUM_PLAYERS  = 4,
  parameter int unsigned X_W          = 8,
  parameter int unsigned Y_W          = 7,
  parameter int unsigned TIMER_LEN    = 159,
  parameter int unsigned TIMER_Y      = 119,
  parameter logic [2:0]  TIMER_COLOUR = 3'b111
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             tick,
  input  logic [NUM_PLAYERS-1:0]           player_en,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] pos,
  input  logic [NUM_PLAYERS*3-1:0]         player_colour,
  input  logic                             plot_ready,
  output logic [X_W-1:0]                   x,
  output logic [Y_W-1:0]                   y,
  output logic [2:0]                       colour,
  output logic                             plot,
  output logic                             running,
  output logic                             round_done,
  output logic [X_W-1:0]                   timer_x
);

  localparam int unsigned PosW = X_W + Y_W;
  localparam int unsigned IdxW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  typedef enum logic [1:0] {StIdle, StPlayer, StTimer, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, load_idx;
  logic            expired_q, expired_d;
  logic [X_W-1:0]  x_d, timer_x_d, slot_x;
  logic [Y_W-1:0]  y_d, slot_y;
  logic [2:0]      colour_d, slot_colour;
  logic            plot_d, running_d, round_done_d, slot_en;
  logic            load_player, load_timer;

  // Player slot selected for the next load
  always_comb begin
    slot_x      = '0;
    slot_y      = '0;
    slot_colour = '0;
    slot_en     = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (load_idx == IdxW'(i)) begin
        slot_x      = pos[i*PosW+Y_W +: X_W];
        slot_y      = pos[i*PosW +: Y_W];
        slot_colour = player_colour[i*3 +: 3];
        slot_en     = player_en[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    expired_d    = expired_q;
    x_d          = x;
    y_d          = y;
    colour_d     = colour;
    plot_d       = plot;
    running_d    = running;
    round_done_d = 1'b0;
    timer_x_d    = timer_x;
    load_player  = 1'b0;
    load_timer   = 1'b0;
    load_idx     = idx_q;

    if (tick && running) begin
      if (timer_x == X_W'(TIMER_LEN - 1)) begin
        expired_d = 1'b1;
      end else begin
        timer_x_d = timer_x + X_W'(1);
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        plot_d = 1'b0;
        if (start) begin
          state_d     = StPlayer;
          idx_d       = '0;
          running_d   = 1'b1;
          timer_x_d   = '0;
          expired_d   = 1'b0;
          load_player = 1'b1;
          load_idx    = '0;
        end
      end
      StPlayer: begin
        // A disabled slot was loaded with plot=0 and advances after one cycle
        if (!plot || plot_ready) begin
          if (idx_q == IdxW'(NUM_PLAYERS - 1)) begin
            state_d    = StTimer;
            load_timer = 1'b1;
          end else begin
            idx_d       = idx_q + IdxW'(1);
            load_player = 1'b1;
            load_idx    = idx_q + IdxW'(1);
          end
        end
      end
      StTimer: begin
        if (plot_ready) begin
          round_done_d = 1'b1;
          if (expired_q) begin
            state_d   = StDone;
            plot_d    = 1'b0;
            running_d = 1'b0;
          end else begin
            state_d     = StPlayer;
            idx_d       = '0;
            load_player = 1'b1;
            load_idx    = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_player) begin
      x_d      = slot_x;
      y_d      = slot_y;
      colour_d = slot_colour;
      plot_d   = slot_en;
    end
    // Uses the pre-tick bar length so a coincident tick lands in the next round
    if (load_timer) begin
      x_d      = timer_x;
      y_d      = Y_W'(TIMER_Y);
      colour_d = TIMER_COLOUR;
      plot_d   = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      expired_q  <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      running    <= 1'b0;
      round_done <= 1'b0;
      timer_x    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      expired_q  <= expired_d;
      x          <= x_d;
      y          <= y_d;
      colour     <= colour_d;
      plot       <= plot_d;
      running    <= running_d;
      round_done <= round_done_d;
      timer_x    <= timer_x_d;
    end
  end

endmodule
